// File: rtl/ram_prog_loader.sv
// Front-panel programming sequencer for the 16x8 RAM/MAR block: button cleanup, store/set/clear-all writes.
// Optional per-button debounce counters are compiled in with RAM_PROG_LOADER_DEBOUNCE_EN.
module ram_prog_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] sw_data,
    input  logic [3:0] sw_addr,
    input  logic       store_btn,
    input  logic       set_addr_btn,
    input  logic       clear_all_btn,
    input  logic       run_mode,
    output logic [3:0] dipswitch_addr,
    output logic [7:0] dipswitch_data,
    output logic       prog_mode,
    output logic       addr_select,
    output logic       write_enable,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SETUP     = 4'd1,
        WRITE     = 4'd2,
        HOLD      = 4'd3,
        ADVANCE   = 4'd4,
        WAIT_REL  = 4'd5,
        CLR_SETUP = 4'd6,
        CLR_WRITE = 4'd7,
        CLR_NEXT  = 4'd8
    } state_t;

    // Button bit order: [2] clear_all, [1] set_addr, [0] store
    logic [2:0] raw_s;
    logic [2:0] sync1_r;
    logic [2:0] sync2_r;
    logic [2:0] clean_s;
    logic [2:0] clean_d_r;
    logic [2:0] press_s;

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] addr_r;
    logic [3:0] addr_next_s;
    logic [7:0] data_r;
    logic [7:0] data_next_s;
    logic       we_r;
    logic       we_next_s;
    logic       prog_r;
    logic       prog_next_s;
    logic       busy_r;

    assign raw_s = {clear_all_btn, set_addr_btn, store_btn};

    // Two-flop synchronizer for the raw button levels
    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

`ifdef RAM_PROG_LOADER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt_r [3];
    logic [2:0]       clean_r;

    // Per-button stability counter; the level flips after DEBOUNCE_CYCLES differing samples in a row
    always_ff @(posedge clk) begin
        if (clear) begin
            clean_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= CNT_W'(0);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != clean_r[i]) begin
                    if (db_cnt_r[i] == CNT_LAST) begin
                        clean_r[i]  <= sync2_r[i];
                        db_cnt_r[i] <= CNT_W'(0);
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt_r[i] <= CNT_W'(0);
                end
            end
        end
    end

    assign clean_s = clean_r;
`else
    localparam int debounce_cycles_unused = DEBOUNCE_CYCLES;

    assign clean_s = sync2_r;
`endif

    assign press_s = clean_s & ~clean_d_r;

    // Next-state, address and data selection for the store / set / clear-all sequences
    always_comb begin
        next_state_s = state_r;
        addr_next_s  = addr_r;
        data_next_s  = data_r;
        we_next_s    = 1'b0;
        prog_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!run_mode && press_s[2]) begin
                    addr_next_s  = 4'd0;
                    data_next_s  = 8'h00;
                    next_state_s = CLR_SETUP;
                end else if (!run_mode && press_s[1]) begin
                    addr_next_s  = sw_addr;
                    next_state_s = WAIT_REL;
                end else if (!run_mode && press_s[0]) begin
                    data_next_s  = sw_data;
                    next_state_s = SETUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP:     next_state_s = WRITE;
            WRITE:     next_state_s = HOLD;
            HOLD: begin
                addr_next_s  = addr_r + 4'd1;
                next_state_s = ADVANCE;
            end
            ADVANCE:   next_state_s = WAIT_REL;
            WAIT_REL: begin
                if (clean_s == 3'b000) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_REL;
                end
            end
            CLR_SETUP: next_state_s = CLR_WRITE;
            CLR_WRITE: next_state_s = CLR_NEXT;
            CLR_NEXT: begin
                addr_next_s = addr_r + 4'd1;
                if (addr_r == 4'd15) begin
                    next_state_s = WAIT_REL;
                end else begin
                    next_state_s = CLR_SETUP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        // Strobe only in write states, which are never reached while the bus owns the RAM
        we_next_s   = (next_state_s == WRITE) || (next_state_s == CLR_WRITE);
        prog_next_s = (state_r == IDLE) && run_mode;
    end

    // State and registered output update
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r   <= IDLE;
            addr_r    <= 4'd0;
            data_r    <= 8'h00;
            we_r      <= 1'b0;
            prog_r    <= 1'b0;
            busy_r    <= 1'b0;
            clean_d_r <= 3'b000;
        end else begin
            state_r   <= next_state_s;
            addr_r    <= addr_next_s;
            data_r    <= data_next_s;
            we_r      <= we_next_s;
            prog_r    <= prog_next_s;
            busy_r    <= (next_state_s != IDLE);
            clean_d_r <= clean_s;
        end
    end

    assign dipswitch_addr = addr_r;
    assign dipswitch_data = data_r;
    assign write_enable   = we_r;
    assign prog_mode      = prog_r;
    assign addr_select    = prog_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_ram_prog_loader.sv
// Self-checking bench for ram_prog_loader: directed steps with random data/addresses,
// checked against a 16-entry memory model and an address pointer.
module tb_ram_prog_loader;

`ifdef RAM_PROG_LOADER_DEBOUNCE_EN
    localparam int DEB = 16;
`else
    localparam int DEB = 0;
`endif
    // Raw edge to recognition cycle
    localparam int LAT = 2 + DEB;

    logic       clk = 1'b0;
    logic       clear;
    logic [7:0] sw_data;
    logic [3:0] sw_addr;
    logic       store_btn;
    logic       set_addr_btn;
    logic       clear_all_btn;
    logic       run_mode;
    logic [3:0] dipswitch_addr;
    logic [7:0] dipswitch_data;
    logic       prog_mode;
    logic       addr_select;
    logic       write_enable;
    logic       busy;

    ram_prog_loader #(.DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .clear(clear), .sw_data(sw_data), .sw_addr(sw_addr),
        .store_btn(store_btn), .set_addr_btn(set_addr_btn), .clear_all_btn(clear_all_btn),
        .run_mode(run_mode), .dipswitch_addr(dipswitch_addr), .dipswitch_data(dipswitch_data),
        .prog_mode(prog_mode), .addr_select(addr_select), .write_enable(write_enable), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         c;
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t        wq[$];
    logic [7:0] shadow [16];
    logic [7:0] exp_mem [16];
    logic [3:0] exp_addr;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM-side monitor: every strobe is a write into the shadow memory
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            wq.push_back('{c: cyc, a: dipswitch_addr, d: dipswitch_data});
            shadow[dipswitch_addr] = dipswitch_data;
            check("we_while_prog", {31'd0, prog_mode}, 32'd0);
            check("addr_sel_eq_prog", {31'd0, addr_select}, {31'd0, prog_mode});
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            tick(1);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        tick(LAT + 4);
    endtask

    task automatic press(logic [2:0] btns, int hold);
        {clear_all_btn, set_addr_btn, store_btn} = btns;
        tick(hold);
        {clear_all_btn, set_addr_btn, store_btn} = 3'b000;
        wait_idle();
    endtask

    task automatic do_set(logic [3:0] a);
        sw_addr = a;
        wq.delete();
        press(3'b010, LAT + 4);
        exp_addr = a;
        check("set_nwr", wq.size(), 0);
        check("set_addr", dipswitch_addr, exp_addr);
    endtask

    task automatic do_store(logic [7:0] d, int hold);
        int k;
        sw_data = d;
        wq.delete();
        k = cyc;
        press(3'b001, hold);
        check("store_nwr", wq.size(), 1);
        if (wq.size() > 0) begin
            check("store_wr_addr", wq[0].a, exp_addr);
            check("store_wr_data", wq[0].d, d);
            check("store_latency", wq[0].c, k + LAT + 2);
        end
        exp_mem[exp_addr] = d;
        exp_addr = exp_addr + 4'd1;
        check("store_next_addr", dipswitch_addr, exp_addr);
    endtask

    task automatic do_clear_all(logic with_store);
        int k;
        sw_data = 8'($urandom_range(255, 1));
        wq.delete();
        k = cyc;
        press(with_store ? 3'b101 : 3'b100, LAT + 4);
        check("clr_nwr", wq.size(), 16);
        for (int i = 0; i < 16 && i < wq.size(); i++) begin
            check("clr_wr_addr", wq[i].a, i);
            check("clr_wr_data", wq[i].d, 8'h00);
        end
        if (wq.size() == 16) begin
            check("clr_first_latency", wq[0].c, k + LAT + 2);
            check("clr_span", wq[15].c - wq[0].c, 45);
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        exp_addr = 4'd0;
        check("clr_final_addr", dipswitch_addr, 4'd0);
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) check("mem", shadow[i], exp_mem[i]);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_addr"}, dipswitch_addr, 4'd0);
        check({tag, "_data"}, dipswitch_data, 8'h00);
        check({tag, "_prog"}, {31'd0, prog_mode}, 32'd0);
        check({tag, "_asel"}, {31'd0, addr_select}, 32'd0);
        check({tag, "_we"}, {31'd0, write_enable}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        clear = 1'b1;
        sw_data = 8'h00;
        sw_addr = 4'h0;
        {clear_all_btn, set_addr_btn, store_btn} = 3'b000;
        run_mode = 1'b0;
        exp_addr = 4'd0;
        tick(3);
        check_reset_outputs("reset");
        clear = 1'b0;
        tick(2);

        // Set A, store CF, address advances to B
        do_set(4'hA);
        do_store(8'hCF, LAT + 4);

        // Wrap from F to 0
        do_set(4'hF);
        do_store(8'h11, LAT + 4);
        do_store(8'h22, LAT + 4);
        check("wrap_final_addr", dipswitch_addr, 4'd1);

        // Clear-all sweep from a nonzero address
        do_set(4'h7);
        do_clear_all(1'b0);
        check_mem();

        // Random mix of set/store
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(2, 0) == 0) do_set(4'($urandom_range(15, 0)));
            else do_store(8'($urandom_range(255, 0)), LAT + 4);
        end
        check_mem();

        // Long hold (with a short bounce first when debounce is built in): exactly one write
`ifdef RAM_PROG_LOADER_DEBOUNCE_EN
        store_btn = 1'b1;
        tick(3);
        store_btn = 1'b0;
        tick(3);
`endif
        do_store(8'($urandom_range(255, 0)), 200);

        // run_mode in IDLE hands the RAM over and discards presses
        run_mode = 1'b1;
        tick(1);
        check("run_prog", {31'd0, prog_mode}, 32'd1);
        check("run_asel", {31'd0, addr_select}, 32'd1);
        sw_data = 8'($urandom_range(255, 0));
        wq.delete();
        press(3'b001, LAT + 4);
        check("run_nwr", wq.size(), 0);
        check("run_busy", {31'd0, busy}, 32'd0);
        run_mode = 1'b0;
        tick(1);
        check("run_off_prog", {31'd0, prog_mode}, 32'd0);

        // run_mode rising mid-store: write completes, prog_mode waits for IDLE
        sw_data = 8'($urandom_range(255, 0));
        wq.delete();
        store_btn = 1'b1;
        tick(LAT + 2);
        run_mode = 1'b1;
        store_btn = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            check("mid_prog_low", {31'd0, prog_mode}, 32'd0);
            tick(1);
            n++;
        end
        check("mid_idle", {31'd0, busy}, 32'd0);
        check("mid_prog_at_idle", {31'd0, prog_mode}, 32'd0);
        tick(1);
        check("mid_prog_after", {31'd0, prog_mode}, 32'd1);
        check("mid_nwr", wq.size(), 1);
        exp_mem[exp_addr] = sw_data;
        exp_addr = exp_addr + 4'd1;
        check("mid_addr", dipswitch_addr, exp_addr);
        run_mode = 1'b0;
        tick(LAT + 4);

        // clear during the WRITE cycle
        sw_data = 8'($urandom_range(255, 0));
        wq.delete();
        store_btn = 1'b1;
        n = 0;
        while (write_enable !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("wr_seen", {31'd0, write_enable}, 32'd1);
        clear = 1'b1;
        store_btn = 1'b0;
        exp_mem[exp_addr] = sw_data;
        exp_addr = 4'd0;
        tick(1);
        check_reset_outputs("midclr");
        clear = 1'b0;
        tick(LAT + 4);
        check("midclr_nwr", wq.size(), 1);
        check("midclr_idle", {31'd0, busy}, 32'd0);

        // Simultaneous clear_all + store: only the sweep runs
        do_set(4'h3);
        do_clear_all(1'b1);
        check_mem();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
